vector_mul_seq_param: RTL
=========================

Name: vector_mul_seq_param

Overview:
- Parametrised successor of the Saber vector-multiply wrapper. Sequences an L-polynomial inner product on the existing 256-coefficient polynomial multiplier, accumulating results across iterations.
- Computes per-polynomial read base addresses by stride accumulation rather than hard-coded muxes, so one block serves LightSaber, Saber and FireSaber (L = 2, 3, 4).
- Sits between the instruction decoder (start/done handshake), the shared 64-bit data memory and the multiplier core.

Parameters:
L, 3, number of polynomial pairs accumulated (2..4)
AW, 9, memory address width
POLY_WORDS_PACKED, 52, 64-bit words per 13-bit-packed polynomial (stride in packed mode)
POLY_WORDS_4X, 64, 64-bit words per polynomial of 4 x uint16 coefficients (stride in coeff4x mode)
S_WORDS, 16, 64-bit words per secret polynomial (s stride)
RES_WORDS, 64, 64-bit result words written back

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle request; sampled only in IDLE
pol_load_coeff4x  in  1  mode; latched at start
a_base  in  AW  base of the first public polynomial; latched at start
s_base  in  AW  base of the first secret polynomial; latched at start
res_base  in  AW  write-back base; latched at start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when write-back completes
pm_rst  out  1  multiplier restart pulse (active-high)
pm_acc_clear  out  1  multiplier accumulator clear, valid with pm_rst
pm_done  in  1  multiplier completion pulse
pm_pol_addr  in  7  multiplier public-poly word index
pm_s_addr  in  8  multiplier secret word index
pm_s_load  in  1  multiplier selects the s address this cycle
pm_result_read  out  1  multiplier result-shift strobe
read_address  out  AW  memory read address
write_address  out  AW  memory write address
wen  out  1  memory write enable

Behaviour:
- Reset (rst low, async): FSM=IDLE; idx=0; all pointers and counters 0; busy, done, pm_rst, pm_acc_clear, pm_result_read and wen 0; pm_rst is 1 only as an FSM pulse, never held.
- States: IDLE -> LAUNCH -> RUN -> (LAUNCH | DRAIN) -> FLUSH -> FIN -> IDLE.
- IDLE: on start=1, latch mode and bases; a_ptr=a_base, s_ptr=s_base, idx=0; go to LAUNCH. Any start outside IDLE is ignored with no side effect.
- LAUNCH (1 cycle): pm_rst=1; pm_acc_clear=1 only when idx==0, so iterations 1..L-1 accumulate; go to RUN.
- RUN: read_address = pm_s_load ? s_ptr+pm_s_addr : a_ptr+pm_pol_addr, with the sum truncated to AW bits (wrap). On pm_done:
  - if idx==L-1, go to DRAIN with cnt=0;
  - else idx+=1, a_ptr+=stride (POLY_WORDS_4X if coeff4x, else POLY_WORDS_PACKED), s_ptr+=S_WORDS, and go to LAUNCH.
- DRAIN: pm_result_read=1 for exactly RES_WORDS cycles; cnt counts 0..RES_WORDS-1. The multiplier's output word is valid one cycle after each strobe.
  - wen and write_address are registered copies of (DRAIN, res_base+cnt), so wen is high for RES_WORDS consecutive cycles starting 1 cycle after the first strobe.
- FLUSH (1 cycle): last delayed write is issued.
- FIN: done=1 for one cycle; busy drops in the same cycle; go to IDLE.
- read_address is 0 outside RUN. write_address holds its last value when wen=0.
- pm_done arriving outside RUN is ignored.
- Total cycles from start to done = L*(2+T_pm) + RES_WORDS + 2, where T_pm is the multiplier run length in cycles.

Test Plan:
- L=3, packed, a_base=0, s_base=0, res_base=200: mock pm_done after 10 cycles -> pm_rst pulses 3 times with pm_acc_clear only on the first; a_ptr is 0, 52, 104; s_ptr is 0, 16, 32; wen high 64 cycles at addresses 200..263 truncated to 9 bits (200..255, then 0..7); done 1 cycle.
- Same run with pol_load_coeff4x=1 -> a_ptr is 0, 64, 128; pm_pol_addr=5 with pm_s_load=0 during the second iteration -> read_address=69.
- L=2 and L=4 builds -> exactly L launches; start-to-done = L*12+66 cycles with T_pm=10.
- start pulsed in RUN and in DRAIN -> ignored; single done; bases unchanged from first latch.
- rst low mid-DRAIN -> wen, busy and pm_result_read are 0 asynchronously; after release, a new start runs a full, correct sequence.
- pm_done in IDLE, and spurious pm_done in LAUNCH -> no state change.

Source files
------------

// File: rtl/vector_mul_seq_param.sv
// vector_mul_seq_param: sequences an L-term polynomial inner product on the shared multiplier
// and streams the accumulated result back to memory; read bases advance by stride accumulation.
module vector_mul_seq_param #(
    parameter int L                 = 3,
    parameter int AW                = 9,
    parameter int POLY_WORDS_PACKED = 52,
    parameter int POLY_WORDS_4X     = 64,
    parameter int S_WORDS           = 16,
    parameter int RES_WORDS         = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pol_load_coeff4x,
    input  logic [AW-1:0] a_base,
    input  logic [AW-1:0] s_base,
    input  logic [AW-1:0] res_base,
    output logic          busy,
    output logic          done,
    output logic          pm_rst,
    output logic          pm_acc_clear,
    input  logic          pm_done,
    input  logic [6:0]    pm_pol_addr,
    input  logic [7:0]    pm_s_addr,
    input  logic          pm_s_load,
    output logic          pm_result_read,
    output logic [AW-1:0] read_address,
    output logic [AW-1:0] write_address,
    output logic          wen
);
    localparam int IW = $clog2(L + 1);
    localparam int CW = $clog2(RES_WORDS + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DRAIN, FLUSH, FIN} state_t;

    state_t        state, state_nx;
    logic          mode_q;
    logic [AW-1:0] a_ptr, s_ptr, res_q;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          last, drain_end;

    assign last      = idx == IW'(L - 1);
    assign drain_end = cnt == CW'(RES_WORDS - 1);

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    always_comb begin
        state_nx       = state;
        busy           = state inside {LAUNCH, RUN, DRAIN, FLUSH};
        done           = state == FIN;
        pm_rst         = state == LAUNCH;
        pm_acc_clear   = state == LAUNCH && idx == '0;
        pm_result_read = state == DRAIN;
        read_address   = state != RUN ? '0 :
                         pm_s_load ? s_ptr + AW'(pm_s_addr) : a_ptr + AW'(pm_pol_addr);
        case (state)
            IDLE:    state_nx = start ? LAUNCH : IDLE;
            LAUNCH:  state_nx = RUN;
            RUN:     state_nx = !pm_done ? RUN : last ? DRAIN : LAUNCH;
            DRAIN:   state_nx = drain_end ? FLUSH : DRAIN;
            FLUSH:   state_nx = FIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            mode_q        <= 1'b0;
            a_ptr         <= '0;
            s_ptr         <= '0;
            res_q         <= '0;
            idx           <= '0;
            cnt           <= '0;
            wen           <= 1'b0;
            write_address <= '0;
        end else begin
            if (state == IDLE && start) begin
                mode_q <= pol_load_coeff4x;
                a_ptr  <= a_base;
                s_ptr  <= s_base;
                res_q  <= res_base;
                idx    <= '0;
            end
            if (state == RUN && pm_done && !last) begin
                idx   <= idx + IW'(1);
                a_ptr <= a_ptr + (mode_q ? AW'(POLY_WORDS_4X) : AW'(POLY_WORDS_PACKED));
                s_ptr <= s_ptr + AW'(S_WORDS);
            end
            cnt <= state == DRAIN ? cnt + CW'(1) : '0;
            // result word lags its strobe by one cycle, so the write trails DRAIN by one
            wen <= state == DRAIN;
            if (state == DRAIN) write_address <= res_q + AW'(cnt);
        end
endmodule
